// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the datapath-without-control block: fetch, decode, execute, memory, writeback.
// Optional build macro OVERFLOW_TRAP_EN: ALU/ADDI overflow in EXEC suppresses comp_write and halts the core.
module multicycle_control_unit #(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int INST_W            = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INST_W-1:0] instruction,
  input  logic              overflow,
  output logic              MemWrite,
  output logic [1:0]        MemSrc,
  output logic [2:0]        MemDst,
  output logic [2:0]        PCSrc,
  output logic [1:0]        SPSrc,
  output logic              PCWrite,
  output logic              SPWrite,
  output logic              InstWrite,
  output logic              mary_write,
  output logic              shelley_write,
  output logic              comp_write,
  output logic              ra_write,
  output logic [1:0]        mary_src,
  output logic [1:0]        shelley_src,
  output logic              ra_src,
  output logic              SrcA,
  output logic [1:0]        SrcB,
  output logic [3:0]        AluOp,
  output logic              halted,
  output logic [2:0]        state_out
);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_LW   = 6'h11;
  localparam logic [5:0] OP_SW   = 6'h12;
  localparam logic [5:0] OP_BEQZ = 6'h13;
  localparam logic [5:0] OP_JAL  = 6'h14;
  localparam logic [5:0] OP_JR   = 6'h15;
  localparam logic [5:0] OP_PUSH = 6'h16;
  localparam logic [5:0] OP_POP  = 6'h17;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD_CYCLES);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_holdCnt;
  logic [5:0] r_op;
  logic       w_isArith;
  logic       w_trap;
  logic       w_unused_bits;

  assign w_isArith = (r_op[5:4] == 2'b00) || (r_op == OP_ADDI);

`ifdef OVERFLOW_TRAP_EN
  assign w_trap        = (r_state == S_EXEC) && w_isArith && overflow;
  assign w_unused_bits = ^instruction[9:0];
`else
  assign w_trap        = 1'b0;
  assign w_unused_bits = ^{instruction[9:0], overflow};
`endif

  // Opcode is latched in DECODE so EXEC/MEM/WB strobes depend only on registered state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_HOLD;
      r_holdCnt <= HOLD_INIT;
      r_op      <= 6'd0;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_HOLD && r_holdCnt != 4'd0)
        r_holdCnt <= r_holdCnt - 4'd1;
      if (r_state == S_DECODE)
        r_op <= instruction[15:10];
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_HOLD:   if (r_holdCnt == 4'd0) w_nextState = S_FETCH;
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: w_nextState = S_EXEC;
      S_EXEC: begin
        if (w_trap)
          w_nextState = S_HALT;
        else begin
          case (r_op)
            OP_LW, OP_PUSH, OP_POP: w_nextState = S_MEM;
            OP_HALT:                w_nextState = S_HALT;
            default:                w_nextState = S_FETCH;
          endcase
        end
      end
      S_MEM:    w_nextState = (r_op == OP_LW || r_op == OP_POP) ? S_WB : S_FETCH;
      S_WB:     w_nextState = S_FETCH;
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_HOLD;
    endcase
  end

  always_comb begin
    MemWrite      = 1'b0;
    MemSrc        = 2'b00;
    MemDst        = 3'b000;
    PCSrc         = 3'b000;
    SPSrc         = 2'b00;
    PCWrite       = 1'b0;
    SPWrite       = 1'b0;
    InstWrite     = 1'b0;
    mary_write    = 1'b0;
    shelley_write = 1'b0;
    comp_write    = 1'b0;
    ra_write      = 1'b0;
    mary_src      = 2'b00;
    shelley_src   = 2'b00;
    ra_src        = 1'b0;
    SrcA          = 1'b0;
    SrcB          = 2'b00;
    AluOp         = 4'b0000;
    halted        = 1'b0;
    state_out     = r_state;
    case (r_state)
      S_FETCH: begin
        InstWrite = 1'b1;
        PCWrite   = 1'b1;
      end
      S_EXEC: begin
        if (r_op[5:4] == 2'b00) begin
          AluOp      = r_op[3:0];
          comp_write = !w_trap;
        end else begin
          case (r_op)
            OP_ADDI: begin
              SrcB       = 2'b01;
              comp_write = !w_trap;
            end
            OP_SW: begin
              MemSrc   = 2'b10;
              MemWrite = 1'b1;
            end
            OP_BEQZ: begin
              PCSrc   = 3'b010;
              PCWrite = 1'b1;
            end
            OP_JAL: begin
              ra_write = 1'b1;
              PCSrc    = 3'b011;
              PCWrite  = 1'b1;
            end
            OP_JR: begin
              PCSrc   = 3'b100;
              PCWrite = 1'b1;
            end
            OP_PUSH: begin
              MemSrc   = 2'b01;
              MemDst   = 3'b010;
              MemWrite = 1'b1;
            end
            OP_POP: begin
              SPSrc   = 2'b01;
              SPWrite = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MEM: begin
        if (r_op == OP_LW)   MemSrc  = 2'b10;
        if (r_op == OP_PUSH) SPWrite = 1'b1;
        if (r_op == OP_POP)  MemSrc  = 2'b01;
      end
      S_WB: begin
        if (r_op == OP_LW) begin
          MemSrc     = 2'b10;
          mary_src   = 2'b01;
          mary_write = 1'b1;
        end
        if (r_op == OP_POP) begin
          ra_src   = 1'b1;
          ra_write = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit: per-cycle expected state and control bundle via a scoreboard queue.
// Expectations for the overflow case follow OVERFLOW_TRAP_EN when the bundle is built with it.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       MemWrite;
    logic [1:0] MemSrc;
    logic [2:0] MemDst;
    logic [2:0] PCSrc;
    logic [1:0] SPSrc;
    logic       PCWrite, SPWrite, InstWrite;
    logic       mary_write, shelley_write, comp_write, ra_write;
    logic [1:0] mary_src, shelley_src;
    logic       ra_src, SrcA;
    logic [1:0] SrcB;
    logic [3:0] AluOp;
    logic       halted;
  } ctrl_t;

  typedef struct {
    int          id;
    logic        rst;
    logic [15:0] instr;
    logic        ovf;
    logic [2:0]  st;
    ctrl_t       c;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        overflow = 1'b0;
  logic        MemWrite, PCWrite, SPWrite, InstWrite;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic        ra_src, SrcA, halted;
  logic [1:0]  MemSrc, SPSrc, mary_src, shelley_src, SrcB;
  logic [2:0]  MemDst, PCSrc, state_out;
  logic [3:0]  AluOp;
  ctrl_t       actCtrl;

  vec_t tbl[$];
  vec_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  int   rowId = 0;

  multicycle_control_unit #(.RESET_HOLD_CYCLES(2), .INST_W(16)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .overflow(overflow),
    .MemWrite(MemWrite), .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
    .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
    .mary_write(mary_write), .shelley_write(shelley_write), .comp_write(comp_write), .ra_write(ra_write),
    .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src), .SrcA(SrcA), .SrcB(SrcB),
    .AluOp(AluOp), .halted(halted), .state_out(state_out)
  );

  assign actCtrl = {MemWrite, MemSrc, MemDst, PCSrc, SPSrc, PCWrite, SPWrite, InstWrite,
                    mary_write, shelley_write, comp_write, ra_write, mary_src, shelley_src,
                    ra_src, SrcA, SrcB, AluOp, halted};

  always #5 clock = ~clock;

  function automatic vec_t mk(input logic rst, input logic [15:0] instr, input logic ovf, input logic [2:0] st);
    vec_t v;
    v.id    = 0;
    v.rst   = rst;
    v.instr = instr;
    v.ovf   = ovf;
    v.st    = st;
    v.c     = '0;
    return v;
  endfunction

  task automatic addRow(input vec_t v);
    rowId = rowId + 1;
    v.id = rowId;
    tbl.push_back(v);
  endtask

  task automatic addFetchDecode(input logic [15:0] instr, input logic ovf);
    vec_t v;
    v = mk(1'b1, instr, ovf, 3'd1);
    v.c.InstWrite = 1'b1;
    v.c.PCWrite   = 1'b1;
    addRow(v);
    addRow(mk(1'b1, instr, ovf, 3'd2));
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sbQ.size() == 0) begin
      total = total + 1;
      bad = bad + 1;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, need one");
    end else begin
      e = sbQ.pop_front();
      total = total + 1;
      if (state_out !== e.st) begin
        bad = bad + 1;
        $display("[TB] FAIL state row %0d: got %0d, need %0d", e.id, state_out, e.st);
      end
      total = total + 1;
      if (actCtrl !== e.c) begin
        bad = bad + 1;
        $display("[TB] FAIL ctrl row %0d: got %h, need %h", e.id, actCtrl, e.c);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    reset       = v.rst;
    instruction = v.instr;
    overflow    = v.ovf;
    sbQ.push_back(v);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  // Drop reset asynchronously 3 time units after an edge and check outputs before any further edge.
  task automatic asyncResetCheck(input int id);
    vec_t v;
    #2;
    reset = 1'b0;
    #1;
    v = mk(1'b0, instruction, 1'b0, 3'd0);
    v.id = id;
    sbQ.push_back(v);
    checkOutput();
  endtask

  initial begin
    vec_t v;

    for (int i = 0; i < 3; i++) addRow(mk(1'b0, 16'h5800, 1'b0, 3'd0));
    addRow(mk(1'b1, 16'h0000, 1'b0, 3'd0));
    addRow(mk(1'b1, 16'h0000, 1'b0, 3'd0));

    addFetchDecode(16'h0000, 1'b0);
    v = mk(1'b1, 16'h0000, 1'b0, 3'd3); v.c.comp_write = 1'b1; addRow(v);

    addFetchDecode(16'h1400, 1'b0);
    v = mk(1'b1, 16'h1400, 1'b0, 3'd3); v.c.comp_write = 1'b1; v.c.AluOp = 4'b0101; addRow(v);

    addFetchDecode(16'h4400, 1'b0);
    addRow(mk(1'b1, 16'h4400, 1'b0, 3'd3));
    v = mk(1'b1, 16'h4400, 1'b0, 3'd4); v.c.MemSrc = 2'b10; addRow(v);
    v = mk(1'b1, 16'h4400, 1'b0, 3'd5); v.c.MemSrc = 2'b10; v.c.mary_src = 2'b01; v.c.mary_write = 1'b1; addRow(v);

    addFetchDecode(16'h4800, 1'b0);
    v = mk(1'b1, 16'h4800, 1'b0, 3'd3); v.c.MemSrc = 2'b10; v.c.MemWrite = 1'b1; addRow(v);

    addFetchDecode(16'h5800, 1'b0);
    v = mk(1'b1, 16'h5800, 1'b0, 3'd3); v.c.MemSrc = 2'b01; v.c.MemDst = 3'b010; v.c.MemWrite = 1'b1; addRow(v);
    v = mk(1'b1, 16'h5800, 1'b0, 3'd4); v.c.SPWrite = 1'b1; addRow(v);

    addFetchDecode(16'h5C00, 1'b0);
    v = mk(1'b1, 16'h5C00, 1'b0, 3'd3); v.c.SPSrc = 2'b01; v.c.SPWrite = 1'b1; addRow(v);
    v = mk(1'b1, 16'h5C00, 1'b0, 3'd4); v.c.MemSrc = 2'b01; addRow(v);
    v = mk(1'b1, 16'h5C00, 1'b0, 3'd5); v.c.ra_src = 1'b1; v.c.ra_write = 1'b1; addRow(v);

    addFetchDecode(16'h5000, 1'b0);
    v = mk(1'b1, 16'h5000, 1'b0, 3'd3); v.c.ra_write = 1'b1; v.c.PCSrc = 3'b011; v.c.PCWrite = 1'b1; addRow(v);

    addFetchDecode(16'h4000, 1'b0);
    v = mk(1'b1, 16'h4000, 1'b0, 3'd3); v.c.SrcB = 2'b01; v.c.comp_write = 1'b1; addRow(v);

    addFetchDecode(16'h4C00, 1'b0);
    v = mk(1'b1, 16'h4C00, 1'b0, 3'd3); v.c.PCSrc = 3'b010; v.c.PCWrite = 1'b1; addRow(v);

    addFetchDecode(16'h5400, 1'b0);
    v = mk(1'b1, 16'h5400, 1'b0, 3'd3); v.c.PCSrc = 3'b100; v.c.PCWrite = 1'b1; addRow(v);

    addFetchDecode(16'h8000, 1'b0);
    addRow(mk(1'b1, 16'h8000, 1'b0, 3'd3));

    addFetchDecode(16'h0000, 1'b1);
`ifdef OVERFLOW_TRAP_EN
    addRow(mk(1'b1, 16'h0000, 1'b1, 3'd3));
`else
    v = mk(1'b1, 16'h0000, 1'b1, 3'd3); v.c.comp_write = 1'b1; addRow(v);
    addFetchDecode(16'hFC00, 1'b0);
    addRow(mk(1'b1, 16'hFC00, 1'b0, 3'd3));
`endif
    for (int i = 0; i < 10; i++) begin
      v = mk(1'b1, 16'hFC00, 1'b0, 3'd6); v.c.halted = 1'b1; addRow(v);
    end

    $display("[TB] applying %0d table rows", tbl.size());
    foreach (tbl[i]) applyStimulus(tbl[i]);

    asyncResetCheck(200);
    applyStimulus(mk(1'b0, 16'h4400, 1'b0, 3'd0));
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd0));
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd0));
    v = mk(1'b1, 16'h4400, 1'b0, 3'd1); v.c.InstWrite = 1'b1; v.c.PCWrite = 1'b1; v.id = 201;
    applyStimulus(v);
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd2));
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd3));
    v = mk(1'b1, 16'h4400, 1'b0, 3'd4); v.c.MemSrc = 2'b10; v.id = 202;
    applyStimulus(v);

    asyncResetCheck(300);
    applyStimulus(mk(1'b0, 16'h4400, 1'b0, 3'd0));
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd0));
    applyStimulus(mk(1'b1, 16'h4400, 1'b0, 3'd0));
    v = mk(1'b1, 16'h4400, 1'b0, 3'd1); v.c.InstWrite = 1'b1; v.c.PCWrite = 1'b1; v.id = 301;
    applyStimulus(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle control FSM driving every control input of the datapath-without-control block.
- Consumes the latched `instruction` and `overflow` fed back from the datapath.
- Emits per-state control strobes and mux selects, one instruction at a time: fetch, decode, execute, optional memory/writeback.
- Together with the datapath it forms the complete processor top.

Parameters:
- RESET_HOLD_CYCLES, 2, idle cycles after reset release before the first FETCH (range 0-15).
- INST_W, 16, instruction width. Fixed at 16; other values unsupported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  16  latched instruction from the datapath. Opcode op=[15:10], immediate [9:2], [1:0] ignored.
- overflow  in  1  ALU overflow from the datapath.
- MemWrite  out  1  memory write strobe.
- MemSrc  out  2  memory address select: 00 pc, 01 sp, 10 comp+ls_imm.
- MemDst  out  3  memory write-data select: 000 mary, 001 shelley, 010 ra, 011 comp.
- PCSrc  out  3  PC next select: 000 pc+2, 001 pc+sext_imm, 010 conditional (comp==0 ? pc+sext_imm : pc+2), 011 ze_imm jump, 100 ra.
- SPSrc  out  2  00 sp-2, 01 sp+2.
- PCWrite, SPWrite, InstWrite  out  1 each  register write enables.
- mary_write, shelley_write, comp_write, ra_write  out  1 each  register-file write enables.
- mary_src, shelley_src  out  2 each  00 comp, 01 memval, 10 zext_imm.
- ra_src  out  1  0 pc, 1 memval.
- SrcA  out  1  0 mary, 1 sp.
- SrcB  out  2  00 shelley, 01 sext_imm, 10 zext_imm.
- AluOp  out  4  ALU function.
- halted  out  1  core stopped.
- state_out  out  3  current FSM state, for debug.

Behaviour:
- States (3-bit encoding): HOLD=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset low: state=HOLD, hold counter loaded with RESET_HOLD_CYCLES, all outputs 0.
- Reset releasing mid-instruction aborts that instruction; no write strobe may assert during reset.
- Strobes are Moore outputs decoded from the registered state plus the registered opcode. Every strobe is 0 in any state not listed below.
- HOLD: counter decrements each cycle; goes to FETCH when it reaches 0 (immediately if RESET_HOLD_CYCLES=0).
- FETCH: MemSrc=00, InstWrite=1, PCWrite=1, PCSrc=000. Next state is DECODE.
- DECODE: captures op into an internal register; no strobes. Next state is EXEC.
- Per-opcode EXEC/MEM/WB behaviour, then return to FETCH:
  - op 0x00-0x0F ALU: EXEC SrcA=0, SrcB=00, AluOp=op[3:0], comp_write=1. 3 cycles.
  - 0x10 ADDI: EXEC SrcB=01, AluOp=0000, comp_write=1. 3 cycles.
  - 0x11 LW: EXEC (address setup) MEM MemSrc=10; WB MemSrc=10, mary_src=01, mary_write=1. 5 cycles.
  - 0x12 SW: EXEC MemSrc=10, MemDst=000, MemWrite=1 for exactly one cycle. 3 cycles.
  - 0x13 BEQZ: EXEC PCSrc=010, PCWrite=1. 3 cycles.
  - 0x14 JAL: EXEC ra_src=0, ra_write=1, PCSrc=011, PCWrite=1 in the same cycle (ra captures pc+2 already in PC). 3 cycles.
  - 0x15 JR: EXEC PCSrc=100, PCWrite=1. 3 cycles.
  - 0x16 PUSH: EXEC MemSrc=01, MemDst=010, MemWrite=1; MEM SPSrc=00, SPWrite=1. 4 cycles.
  - 0x17 POP: EXEC SPSrc=01, SPWrite=1; MEM MemSrc=01; WB ra_src=1, ra_write=1. 5 cycles.
  - 0x3F HALT: EXEC goes to HALT.
  - All other opcodes: NOP, EXEC has no strobes. 3 cycles.
- HALT: halted=1, all strobes 0. Only reset exits.
- overflow is ignored unless the optional feature is enabled.

Optional Feature:
- Macro OVERFLOW_TRAP_EN.
- Defined: in EXEC of an ALU or ADDI op with overflow=1, comp_write is forced to 0 and the next state is HALT (halted=1 the following cycle).
- Undefined: overflow is ignored and comp_write proceeds normally.

Test Plan:
- Hold reset low 3 cycles, release, RESET_HOLD_CYCLES=2 -> all outputs 0. state_out 0,0 then 1 on the 3rd cycle after release; InstWrite=1 in that cycle.
- instruction=0x0000 (op ADD) -> FETCH/DECODE/EXEC sequence 1,2,3. EXEC: AluOp=0000, SrcB=00, comp_write=1. Back to FETCH the next cycle.
- instruction=0x4400 (op 0x11 LW) -> states 1,2,3,4,5. WB: mary_write=1, mary_src=01, MemSrc=10. MemWrite stays 0 throughout.
- instruction=0x5800 (op 0x16 PUSH) -> EXEC MemWrite=1 for exactly 1 cycle with MemDst=010. MEM: SPWrite=1, SPSrc=00.
- instruction=0xFC00 (HALT) -> halted=1 and state_out=6 held for 10 cycles. Pulse reset low mid-HALT -> returns to HOLD asynchronously with halted=0.
- With OVERFLOW_TRAP_EN, instruction=0x0000 and overflow=1 in EXEC -> comp_write=0, then halted=1. Without the macro -> comp_write=1 and return to FETCH.
